resize_feeder: RTL
==================

RESIZE_FEEDER -- requirements
Module: resize_feeder

Interface
REQ-001 Parameter ROW_WIDTH, default 13, input pixels per row (range 2..1023).
REQ-002 Parameter FRAME_ROWS, default 13, rows per frame; used only under REQ-031.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data carries a valid FP16 pixel.
REQ-006 in_data  input  16  FP16 pixel, row-major order.
REQ-007 in_ready  output  1  feeder accepts in_data this cycle.
REQ-008 out_valid  output  1  data_in1/data_in2/scale form a valid interpolation job.
REQ-009 out_ready  input  1  downstream resize_datapath accepts the job.
REQ-010 data_in1  output  16  FP16 left operand.
REQ-011 data_in2  output  16  FP16 right operand.
REQ-012 scale  output  16  FP16 weight; the job result is data_in1 + scale*(data_in2 - data_in1).
REQ-013 out_last  output  1  marks the final job of a row.
REQ-014 out_frame_last  output  1  marks the final job of a frame (see REQ-031).

Function
REQ-015 The block SHALL emit exactly 2*ROW_WIDTH jobs per row of ROW_WIDTH input pixels p0..pW-1, implementing x2 horizontal upsampling with half-pixel centres.
REQ-016 Job sequence per row SHALL be:
- HEAD: (p0, p0, 16'h0000).
- For k = 0..W-2: (pk, pk+1, 16'h3400 = 0.25), then (pk, pk+1, 16'h3A00 = 0.75).
- TAIL: (pW-1, pW-1, 16'h0000) with out_last = 1.
REQ-017 States SHALL be IDLE, HEAD, FETCH, EMIT_Q1, EMIT_Q3, TAIL.
REQ-018 State transitions:
- IDLE -> HEAD on in_valid&&in_ready; p0 is captured into the left register.
- HEAD -> FETCH on out_ready.
- FETCH -> EMIT_Q1 on input accept; the pixel is captured into the right register.
- EMIT_Q1 -> EMIT_Q3 on out_ready.
- EMIT_Q3 -> FETCH on out_ready if accepted pixels < W; otherwise -> TAIL. On this transition right moves to left.
- TAIL -> IDLE on out_ready.
REQ-019 in_ready SHALL be 1 only in IDLE and FETCH; in_ready SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL be 1 exactly in HEAD, EMIT_Q1, EMIT_Q3 and TAIL.
REQ-021 While out_valid=1 and out_ready=0, data_in1, data_in2, scale, out_last and out_frame_last SHALL hold stable.
REQ-022 Each job SHALL appear on the outputs the cycle after the state is entered (registered outputs), giving a one-cycle latency from input accept to job presentation.
REQ-023 A column counter SHALL count accepted pixels from 0 to W-1 and clear on entry to TAIL; ROW_WIDTH=2 SHALL yield exactly 4 jobs.
REQ-024 Back-to-back rows SHALL be supported: with out_ready held at 1 and in_valid held at 1, the row period SHALL be 3*W cycles (W-1 FETCH cycles, 2W jobs, 1 IDLE accept cycle).
REQ-025 The block SHALL perform no FP16 arithmetic; pixel values SHALL pass bit-exact, including NaN, Inf and subnormals.
REQ-026 in_valid while in_ready=0 SHALL be ignored, and the pixel SHALL NOT be consumed.

Reset
REQ-027 When reset=1 at a clock edge, the state SHALL go to IDLE and the column and row counters SHALL clear.
REQ-028 Reset values: out_valid=0, out_last=0, out_frame_last=0, data_in1=data_in2=scale=16'h0000.
REQ-029 in_ready SHALL be 0 during the reset cycle and 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-row SHALL discard partial row state; the next accepted pixel SHALL be treated as p0 of a new row.

Configuration
REQ-031 Macro RESIZE_FEEDER_FRAME_CNT_EN:
- Defined: a row counter (0..FRAME_ROWS-1) SHALL increment on each TAIL handshake. out_frame_last SHALL be 1 with the TAIL job of row FRAME_ROWS-1, and the counter SHALL then wrap to 0.
- Undefined: the counter SHALL not be built, the port SHALL remain, and out_frame_last SHALL be constant 0.

Verification
REQ-032 W=13, pixels 1.0,2.0,... (16'h3C00,16'h4000,...), out_ready=1 -> 26 jobs. Job0 = (3C00,3C00,0000), job1 = (3C00,4000,3400), job2 = (3C00,4000,3A00). Job25 has out_last=1 and data_in1=data_in2=p12.
REQ-033 Random out_ready stalls (50%) -> the job stream is identical to REQ-032, and the outputs never change while out_valid=1 && out_ready=0.
REQ-034 W=2, inputs 3C00 and 4000 -> exactly 4 jobs: (3C00,3C00,0000), (3C00,4000,3400), (3C00,4000,3A00), (4000,4000,0000) with out_last=1.
REQ-035 Reset asserted after job 7 of a row, then a new row streamed -> the first post-reset job is HEAD of the new p0, with no residual jobs emitted.
REQ-036 Macro defined, FRAME_ROWS=2, 3 rows streamed -> out_frame_last=1 only on the row-1 TAIL. Macro undefined -> out_frame_last=0 throughout.
REQ-037 in_valid and out_ready held at 1, W=13 -> row-to-row HEAD spacing is 39 cycles.

Source files
------------

// File: rtl/resize_feeder_if.sv
// resize_feeder_if -- pixel input stream plus interpolation-job output stream
// for the x2 horizontal resize feeder. The slave modport is the feeder's
// view; the master modport is the view of whatever surrounds it.
interface resize_feeder_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_in1;
  logic [15:0] data_in2;
  logic [15:0] scale;
  logic        out_last;
  logic        out_frame_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, data_in1, data_in2, scale, out_last, out_frame_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, data_in1, data_in2, scale, out_last, out_frame_last
  );
endinterface

// File: rtl/resize_feeder.sv
// resize_feeder -- turns a row-major FP16 pixel stream into interpolation jobs
// (left, right, weight) for x2 horizontal upsampling with half-pixel centres:
// per row one HEAD job, two jobs (0.25 / 0.75) per adjacent pixel pair and one
// TAIL job. Pixels are only steered, never computed on, so every FP16 pattern
// (NaN, Inf, subnormal) passes through bit-exact.
// Optional feature: define RESIZE_FEEDER_FRAME_CNT_EN to build the row counter
// that drives out_frame_last; otherwise out_frame_last is tied to 0.
module resize_feeder #(
  parameter int ROW_WIDTH  = 13,
  parameter int FRAME_ROWS = 13
) (
  input  logic            clk,
  input  logic            reset,
  resize_feeder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEAD    = 3'd1,
    FETCH   = 3'd2,
    EMIT_Q1 = 3'd3,
    EMIT_Q3 = 3'd4,
    TAIL    = 3'd5
  } state_t;

  localparam int              COL_W      = $clog2(ROW_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(ROW_WIDTH - 1);
  localparam logic [15:0]     SCALE_ZERO = 16'h0000;
  localparam logic [15:0]     SCALE_Q1   = 16'h3400;  // 0.25
  localparam logic [15:0]     SCALE_Q3   = 16'h3A00;  // 0.75

  // Catch out-of-range configurations at elaboration.
  if (ROW_WIDTH < 2 || ROW_WIDTH > 1023 || FRAME_ROWS < 1) begin : g_param_check
    $error("resize_feeder: ROW_WIDTH must be 2..1023 and FRAME_ROWS >= 1");
  end

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col_cnt;
  logic [15:0]      left_px;
  logic [15:0]      right_px;
  logic [15:0]      d1_q;
  logic [15:0]      d2_q;
  logic [15:0]      scale_q;
  logic             last_q;
  logic             frame_last_q;
  logic             in_rdy;
  logic             out_vld;
  logic             in_acc;
  logic             out_acc;

  // Handshake strobes decode from the state register only, so in_ready
  // never follows out_ready combinationally.
  assign in_rdy  = ((state == IDLE) || (state == FETCH)) && !reset;
  assign out_vld = (state == HEAD) || (state == EMIT_Q1) ||
                   (state == EMIT_Q3) || (state == TAIL);
  assign in_acc  = bus.in_valid && in_rdy;
  assign out_acc = out_vld && bus.out_ready;

  assign bus.in_ready       = in_rdy;
  assign bus.out_valid      = out_vld;
  assign bus.data_in1       = d1_q;
  assign bus.data_in2       = d2_q;
  assign bus.scale          = scale_q;
  assign bus.out_last       = last_q;
  assign bus.out_frame_last = frame_last_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: input states advance on accept, job states on out_ready.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_acc) state_nxt = HEAD;
      HEAD:    if (bus.out_ready) state_nxt = FETCH;
      FETCH:   if (in_acc) state_nxt = EMIT_Q1;
      EMIT_Q1: if (bus.out_ready) state_nxt = EMIT_Q3;
      EMIT_Q3: if (bus.out_ready) state_nxt = (col_cnt == COL_LAST) ? TAIL : FETCH;
      TAIL:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel window and job registers: each job is loaded on the transition
  // into its state and then held until that state's handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt  <= '0;
      left_px  <= '0;
      right_px <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      scale_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_acc) begin
          left_px <= bus.in_data;
          d1_q    <= bus.in_data;
          d2_q    <= bus.in_data;
          scale_q <= SCALE_ZERO;
          last_q  <= 1'b0;
          col_cnt <= '0;
        end
        FETCH: if (in_acc) begin
          right_px <= bus.in_data;
          d1_q     <= left_px;
          d2_q     <= bus.in_data;
          scale_q  <= SCALE_Q1;
          col_cnt  <= col_cnt + 1'b1;
        end
        EMIT_Q1: if (out_acc) scale_q <= SCALE_Q3;
        EMIT_Q3: if (out_acc) begin
          left_px <= right_px;
          if (col_cnt == COL_LAST) begin
            d1_q    <= right_px;
            d2_q    <= right_px;
            scale_q <= SCALE_ZERO;
            last_q  <= 1'b1;
            col_cnt <= '0;
          end
        end
        TAIL: if (out_acc) last_q <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef RESIZE_FEEDER_FRAME_CNT_EN
  localparam int               ROW_W    = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_ROWS - 1);

  logic [ROW_W-1:0] row_cnt;

  // Row counter: advances on each TAIL handshake; the frame flag rides with
  // the TAIL job of the last row and the counter wraps after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt      <= '0;
      frame_last_q <= 1'b0;
    end else begin
      if (state == EMIT_Q3 && out_acc && col_cnt == COL_LAST)
        frame_last_q <= (row_cnt == ROW_LAST);
      if (state == TAIL && out_acc) begin
        frame_last_q <= 1'b0;
        row_cnt      <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end
    end
  end
`else
  assign frame_last_q = 1'b0;
`endif

endmodule
